sum_checker: RTL and testbench
==============================

Name: sum_checker

Overview:
- Consumer/checker end of the two-operand adder interface: receives beats of operands a, b plus a produced sum c.
- Each beat is checked for c == a + b.
- Keeps pass/error counts and captures the first failing beat.
- Sits downstream of any adder datapath as a self-check monitor with a valid/ready input handshake.

Parameters:
- WIDTH, 8, operand width in bits
- CNT_W, 16, width of the pass and error counters
- STOP_ON_ERR, 1, 1 = halt intake after the first mismatch; 0 = keep running

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- enable  input  1  allows intake when high
- clear  input  1  one-cycle pulse: zero counters and capture, leave HALT
- in_valid  input  1  beat offered
- in_ready  output  1  checker accepts beat
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_c  input  WIDTH+1  sum under test (MSB = carry)
- err_pulse  output  1  one-cycle mismatch strobe
- pass_cnt  output  CNT_W  matching beats, saturating
- err_cnt  output  CNT_W  mismatching beats, saturating
- first_err_valid  output  1  capture registers hold a failing beat
- first_err_a, first_err_b  output  WIDTH  operands of the first failure
- first_err_c  output  WIDTH+1  sum of the first failure
- halted  output  1  FSM in HALT

Behaviour:
- Interface timing:
  - Single clock. Reset is synchronous and active-high on rst; clock is clk.
  - All outputs are registered.
  - On reset every output is 0, both pipeline stages are invalid, and the FSM is in IDLE.
- FSM states:
  - IDLE: in_ready=0.
  - RUN: in_ready=1.
  - HALT: in_ready=0, halted=1.
- FSM transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0. Beats already in the pipeline still complete and are counted.
  - RUN -> HALT on a stage-2 mismatch when STOP_ON_ERR=1. Any valid beat in stage 1 on that edge is flushed and not counted.
  - HALT -> IDLE on clear.
  - in_ready is a registered function of state, so it never depends combinationally on in_valid.
- Accept: in_valid && in_ready on a clk edge.
- Stage 1: registers a, b, c.
- Stage 2:
  - Computes expected = a + b in WIDTH+1 bits (zero-extended, no truncation).
  - Compares expected against c per the optional-feature rule.
  - Updates counters and capture.
- Latency: for a beat accepted at edge k, err_pulse and counter updates are visible after edge k+2. Throughput is one beat per cycle in RUN.
- Counters:
  - Increment by 1 per completed beat.
  - Saturate at 2^CNT_W-1 and never wrap.
- Capture: loaded only when first_err_valid=0 and a mismatch completes; held until clear or rst.
- clear:
  - Zeroes counters, first_err_*, and first_err_valid.
  - Invalidates both pipeline stages.
  - Takes priority over a simultaneous stage-2 completion: that beat is discarded and err_pulse stays 0.
- Simultaneous enable falling and a mismatch: HALT wins when STOP_ON_ERR=1.
- rst mid-operation: immediate return to the reset state. In-flight beats are lost and not counted.

Optional Feature:
- Macro: SUM_CHECKER_CARRY_EN.
- Defined: the full WIDTH+1-bit compare, so in_c[WIDTH] must equal the carry-out.
- Undefined: compare is modulo 2^WIDTH. in_c[WIDTH] is ignored and first_err_c[WIDTH] is captured as 0.

Decomposition:
- sum_checker_pkg holds:
  - state enum: IDLE, RUN, HALT (2-bit)
  - typedef for the stage-1 beat struct (a, b, c, valid), parameterised via WIDTH localparam defaults
  - function sat_inc for the saturating counter
- One sub-module, sum_checker_cmp: purely combinational expected-sum and mismatch logic with the carry-mask selection. It is instantiated once in stage 2.
- All sequential state stays in sum_checker.

Test Plan:
- Reset then enable=1; send a=3, b=4, c=7 -> in_ready=1 one cycle after enable, pass_cnt=1 two cycles after accept, err_pulse never asserted.
- Send a=200, b=100, c=44 (WIDTH=8) -> with the macro: mismatch, err_cnt=1, first_err_c=44. Without the macro: pass (300 mod 256 = 44).
- STOP_ON_ERR=1; back-to-back beats (1,1,2), (2,2,5), (3,3,6) -> err_pulse at the second beat's completion, halted=1, third beat flushed, pass_cnt=1, err_cnt=1, capture holds (2,2,5).
- In HALT pulse clear -> counters 0, first_err_valid=0, FSM to IDLE, then RUN next cycle with enable=1. Also: clear on the same edge as a mismatch completion -> err_cnt stays 0.
- CNT_W=2, send 5 good beats -> pass_cnt saturates at 3.
- Assert rst with two beats in flight -> all outputs 0 next cycle, no err_pulse, counters 0.

Source files
------------

// File: rtl/sum_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_checker_pkg
// Description : Shared types and helpers for the sum_checker block.
//               - state_e  : checker FSM state (2-bit encoding)
//               - beat_t   : shape of one captured beat at the default width
//               - sat_inc  : saturating increment used by the beat counters
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sum_checker_pkg;

    // Default operand width; beat_t is sized from it.
    localparam int WIDTH_DEF = 8;

    // Working width of sat_inc. Counters up to this width are supported.
    localparam int SAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // One beat as it sits in a pipeline stage: operands, sum under test and
    // a valid flag.
    typedef struct packed {
        logic                 valid;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [WIDTH_DEF:0]   c;
    } beat_t;

    // Increment cnt by one unless it already sits at max_val.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] cnt,
        input logic [SAT_W-1:0] max_val
    );
        return (cnt >= max_val) ? cnt : (cnt + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_checker_cmp.sv
`default_nettype none
// ============================================================================
// Module      : sum_checker_cmp
// Description : Combinational expected-sum and mismatch logic for one beat.
//               The expected sum is a + b in WIDTH+1 bits. Which bits take
//               part in the compare is chosen by the carry mask:
//                 SUM_CHECKER_CARRY_EN defined   -> all WIDTH+1 bits
//                 SUM_CHECKER_CARRY_EN undefined -> low WIDTH bits only;
//                   the carry bit of c is ignored and reported as 0.
// Ports       : a_i, b_i     [WIDTH-1:0] operands
//               c_i          [WIDTH:0]   sum under test
//               mismatch_o               1 = masked sum differs from c
//               c_masked_o   [WIDTH:0]   c with the ignored bits cleared
// Revision    : 1.0 - initial release
// ============================================================================
module sum_checker_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH:0]   c_i,
    output logic             mismatch_o,
    output logic [WIDTH:0]   c_masked_o
);

`ifdef SUM_CHECKER_CARRY_EN
    localparam logic [WIDTH:0] C_MASK = {1'b1, {WIDTH{1'b1}}};
`else
    localparam logic [WIDTH:0] C_MASK = {1'b0, {WIDTH{1'b1}}};
`endif

    logic [WIDTH:0] w_expected;

    // Zero-extend before adding so the carry-out lands in the top bit.
    assign w_expected = {1'b0, a_i} + {1'b0, b_i};
    assign mismatch_o = |((w_expected ^ c_i) & C_MASK);
    assign c_masked_o = c_i & C_MASK;

endmodule
`default_nettype wire

// File: rtl/sum_checker.sv
`default_nettype none
// ============================================================================
// Module      : sum_checker
// Description : Self-check monitor for a two-operand adder. Accepts beats
//               (a, b, c) over a valid/ready handshake, checks c == a + b in
//               a two-stage pipeline, keeps saturating pass/error counts and
//               captures the first failing beat. With STOP_ON_ERR=1 the FSM
//               halts intake on the first mismatch until clear.
//               Optional feature macro: SUM_CHECKER_CARRY_EN (full
//               WIDTH+1-bit compare including the carry bit).
// Ports       : clk, rst (sync, active high), enable, clear
//               in_valid / in_ready handshake, in_a, in_b, in_c
//               err_pulse, pass_cnt, err_cnt, first_err_valid,
//               first_err_a, first_err_b, first_err_c, halted
// Revision    : 1.0 - initial release
// ============================================================================
module sum_checker
    import sum_checker_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_c,
    output logic             err_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH:0]   first_err_c,
    output logic             halted
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   c;
    } stage_t;

    localparam logic [SAT_W-1:0] C_CNT_MAX = SAT_W'((64'd1 << CNT_W) - 64'd1);

    state_e           state_q, state_d;
    logic             in_ready_q;
    logic             halted_q;
    stage_t           s1_q;
    stage_t           s2_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             first_err_valid_q;
    logic [WIDTH-1:0] first_err_a_q;
    logic [WIDTH-1:0] first_err_b_q;
    logic [WIDTH:0]   first_err_c_q;

    logic             w_accept;
    logic             w_mismatch;
    logic [WIDTH:0]   w_c_masked;
    logic             w_done_ok;
    logic             w_done_err;
    logic             w_halt;
    logic [CNT_W-1:0] w_pass_inc;
    logic [CNT_W-1:0] w_err_inc;

    sum_checker_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a_i        (s2_q.a),
        .b_i        (s2_q.b),
        .c_i        (s2_q.c),
        .mismatch_o (w_mismatch),
        .c_masked_o (w_c_masked)
    );

    // in_ready_q mirrors state_q == ST_RUN, so this is the registered ready.
    assign w_accept   = in_valid && in_ready_q;

    // clear discards whatever completes on its edge.
    assign w_done_ok  = s2_q.valid && !w_mismatch && !clear;
    assign w_done_err = s2_q.valid &&  w_mismatch && !clear;
    assign w_halt     = (STOP_ON_ERR != 0) && w_done_err && (state_q == ST_RUN);

    assign w_pass_inc = CNT_W'(sat_inc(SAT_W'(pass_cnt_q), C_CNT_MAX));
    assign w_err_inc  = CNT_W'(sat_inc(SAT_W'(err_cnt_q), C_CNT_MAX));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A halting mismatch beats a simultaneous enable drop.
                if (w_halt) begin
                    state_d = ST_HALT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            in_ready_q        <= 1'b0;
            halted_q          <= 1'b0;
            s1_q              <= '0;
            s2_q              <= '0;
            err_pulse_q       <= 1'b0;
            pass_cnt_q        <= '0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_a_q     <= '0;
            first_err_b_q     <= '0;
            first_err_c_q     <= '0;
        end else begin
            state_q    <= state_d;
            // Ready and halted follow the next state so they stay registered
            // and line up with state_q after the edge.
            in_ready_q <= (state_d == ST_RUN);
            halted_q   <= (state_d == ST_HALT);

            if (clear) begin
                s1_q              <= '0;
                s2_q              <= '0;
                err_pulse_q       <= 1'b0;
                pass_cnt_q        <= '0;
                err_cnt_q         <= '0;
                first_err_valid_q <= 1'b0;
                first_err_a_q     <= '0;
                first_err_b_q     <= '0;
                first_err_c_q     <= '0;
            end else begin
                err_pulse_q <= w_done_err;

                if (w_halt) begin
                    // Flush the beat moving out of stage 1 and any beat
                    // accepted on this same edge.
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s2_q <= s1_q;
                    s1_q <= '{valid: w_accept, a: in_a, b: in_b, c: in_c};
                end

                if (w_done_ok) begin
                    pass_cnt_q <= w_pass_inc;
                end
                if (w_done_err) begin
                    err_cnt_q <= w_err_inc;
                end

                if (w_done_err && !first_err_valid_q) begin
                    first_err_valid_q <= 1'b1;
                    first_err_a_q     <= s2_q.a;
                    first_err_b_q     <= s2_q.b;
                    first_err_c_q     <= w_c_masked;
                end
            end
        end
    end

    assign in_ready        = in_ready_q;
    assign halted          = halted_q;
    assign err_pulse       = err_pulse_q;
    assign pass_cnt        = pass_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_a     = first_err_a_q;
    assign first_err_b     = first_err_b_q;
    assign first_err_c     = first_err_c_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_checker
// Description : Self-checking bench for sum_checker. Two instances share the
//               same stimulus: d0 (CNT_W=16, STOP_ON_ERR=1) and d1 (CNT_W=2,
//               STOP_ON_ERR=0). A reference model tracks each instance as a
//               list of in-flight beats that complete two edges after
//               acceptance, plus counters and a first-failure record.
//               Honours SUM_CHECKER_CARRY_EN like the design.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_checker;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [8:0] in_c = '0;

    logic        d0_ready, d0_pulse, d0_fev, d0_halted;
    logic [15:0] d0_pass, d0_err;
    logic [7:0]  d0_fa, d0_fb;
    logic [8:0]  d0_fc;
    logic        d1_ready, d1_pulse, d1_fev, d1_halted;
    logic [1:0]  d1_pass, d1_err;
    logic [7:0]  d1_fa, d1_fb;
    logic [8:0]  d1_fc;

    always #5 clk = ~clk;

    sum_checker #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1)) u_d0 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_ready(d0_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .err_pulse(d0_pulse), .pass_cnt(d0_pass), .err_cnt(d0_err),
        .first_err_valid(d0_fev), .first_err_a(d0_fa), .first_err_b(d0_fb),
        .first_err_c(d0_fc), .halted(d0_halted)
    );

    sum_checker #(.WIDTH(8), .CNT_W(2), .STOP_ON_ERR(0)) u_d1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_ready(d1_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .err_pulse(d1_pulse), .pass_cnt(d1_pass), .err_cnt(d1_err),
        .first_err_valid(d1_fev), .first_err_a(d1_fa), .first_err_b(d1_fb),
        .first_err_c(d1_fc), .halted(d1_halted)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode  [2];
    int m_pass  [2];
    int m_err   [2];
    bit m_pulse [2];
    bit m_cap_v [2];
    int m_cap_a [2];
    int m_cap_b [2];
    int m_cap_c [2];
    // In-flight beats: [0] accepted on the latest edge, [1] one edge older.
    bit m_fl_v  [2][2];
    int m_fl_a  [2][2];
    int m_fl_b  [2][2];
    int m_fl_c  [2][2];

    function automatic bit sum_ok(input int a, input int b, input int c);
`ifdef SUM_CHECKER_CARRY_EN
        return c == (a + b);
`else
        return (c % 256) == ((a + b) % 256);
`endif
    endfunction

    function automatic int seen_c(input int c);
`ifdef SUM_CHECKER_CARRY_EN
        return c;
`else
        return c % 256;
`endif
    endfunction

    function automatic int next_mode(input int mode, input bit en, input bit clr);
        if (mode == M_IDLE && en)   return M_RUN;
        if (mode == M_RUN  && !en)  return M_IDLE;
        if (mode == M_HALT && clr)  return M_IDLE;
        return mode;
    endfunction

    task automatic model_edge(input int i, input int cnt_max, input bit stop);
        bit acc, done, bad;
        acc  = in_valid && (m_mode[i] == M_RUN);
        done = m_fl_v[i][1];
        bad  = done && !sum_ok(m_fl_a[i][1], m_fl_b[i][1], m_fl_c[i][1]);
        if (rst) begin
            m_mode[i] = M_IDLE; m_pass[i] = 0; m_err[i] = 0; m_pulse[i] = 0;
            m_cap_v[i] = 0; m_cap_a[i] = 0; m_cap_b[i] = 0; m_cap_c[i] = 0;
            m_fl_v[i][0] = 0; m_fl_v[i][1] = 0;
        end else if (clear) begin
            m_pass[i] = 0; m_err[i] = 0; m_pulse[i] = 0;
            m_cap_v[i] = 0; m_cap_a[i] = 0; m_cap_b[i] = 0; m_cap_c[i] = 0;
            m_fl_v[i][0] = 0; m_fl_v[i][1] = 0;
            m_mode[i] = next_mode(m_mode[i], enable, 1'b1);
        end else begin
            if (done && bad  && m_err[i]  < cnt_max) m_err[i]++;
            if (done && !bad && m_pass[i] < cnt_max) m_pass[i]++;
            m_pulse[i] = bad;
            if (bad && !m_cap_v[i]) begin
                m_cap_v[i] = 1;
                m_cap_a[i] = m_fl_a[i][1];
                m_cap_b[i] = m_fl_b[i][1];
                m_cap_c[i] = seen_c(m_fl_c[i][1]);
            end
            if (bad && stop && m_mode[i] == M_RUN) begin
                m_mode[i] = M_HALT;
                m_fl_v[i][0] = 0; m_fl_v[i][1] = 0;
            end else begin
                m_fl_v[i][1] = m_fl_v[i][0]; m_fl_a[i][1] = m_fl_a[i][0];
                m_fl_b[i][1] = m_fl_b[i][0]; m_fl_c[i][1] = m_fl_c[i][0];
                m_fl_v[i][0] = acc; m_fl_a[i][0] = int'(in_a);
                m_fl_b[i][0] = int'(in_b); m_fl_c[i][0] = int'(in_c);
                m_mode[i] = next_mode(m_mode[i], enable, 1'b0);
            end
        end
    endtask

    task automatic check_all(input int i);
        logic        rdy, pl, fev, hl;
        logic [31:0] pc, ec, fa, fb, fc;
        if (i == 0) begin
            rdy = d0_ready; pl = d0_pulse; fev = d0_fev; hl = d0_halted;
            pc = 32'(d0_pass); ec = 32'(d0_err);
            fa = 32'(d0_fa); fb = 32'(d0_fb); fc = 32'(d0_fc);
        end else begin
            rdy = d1_ready; pl = d1_pulse; fev = d1_fev; hl = d1_halted;
            pc = 32'(d1_pass); ec = 32'(d1_err);
            fa = 32'(d1_fa); fb = 32'(d1_fb); fc = 32'(d1_fc);
        end
        check($sformatf("d%0d.in_ready", i), 32'(rdy), 32'(m_mode[i] == M_RUN));
        check($sformatf("d%0d.halted", i), 32'(hl), 32'(m_mode[i] == M_HALT));
        check($sformatf("d%0d.err_pulse", i), 32'(pl), 32'(m_pulse[i]));
        check($sformatf("d%0d.pass_cnt", i), pc, m_pass[i]);
        check($sformatf("d%0d.err_cnt", i), ec, m_err[i]);
        check($sformatf("d%0d.first_err_valid", i), 32'(fev), 32'(m_cap_v[i]));
        check($sformatf("d%0d.first_err_a", i), fa, m_cap_a[i]);
        check($sformatf("d%0d.first_err_b", i), fb, m_cap_b[i]);
        check($sformatf("d%0d.first_err_c", i), fc, m_cap_c[i]);
    endtask

    // One clock edge: advance both models, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge(0, 65535, 1'b1);
        model_edge(1, 3, 1'b0);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [8:0] c);
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [8:0] sum;
        int         r;

        // Reset
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset.in_ready", 32'(d0_ready), 0);

        // Enable -> RUN after one edge, then a good beat
        enable = 1'b1;
        idle(1);
        check("enable.in_ready", 32'(d0_ready), 1);
        beat(8'd3, 8'd4, 9'd7);
        idle(2);
        check("good.pass_cnt", 32'(d0_pass), 1);

        // Carry-dependent beat 200 + 100 vs 44
        beat(8'd200, 8'd100, 9'd44);
        idle(2);
`ifdef SUM_CHECKER_CARRY_EN
        check("carry.err_cnt", 32'(d0_err), 1);
        check("carry.first_err_c", 32'(d0_fc), 44);
        check("carry.halted", 32'(d0_halted), 1);
`else
        check("nocarry.pass_cnt", 32'(d0_pass), 2);
        check("nocarry.err_cnt", 32'(d0_err), 0);
`endif
        clear = 1'b1; idle(1); clear = 1'b0; idle(1);

        // Fresh start, back-to-back beats with a failure in the middle
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(1);
        beat(8'd1, 8'd1, 9'd2);
        beat(8'd2, 8'd2, 9'd5);
        beat(8'd3, 8'd3, 9'd6);
        idle(3);
        check("stop.pass_cnt", 32'(d0_pass), 1);
        check("stop.err_cnt", 32'(d0_err), 1);
        check("stop.halted", 32'(d0_halted), 1);
        check("stop.first_err_a", 32'(d0_fa), 2);
        check("stop.first_err_b", 32'(d0_fb), 2);
        check("stop.first_err_c", 32'(d0_fc), 5);
        check("nostop.pass_cnt", 32'(d1_pass), 2);

        // clear out of HALT
        clear = 1'b1; idle(1); clear = 1'b0;
        check("clear.pass_cnt", 32'(d0_pass), 0);
        check("clear.first_err_valid", 32'(d0_fev), 0);
        check("clear.in_ready", 32'(d0_ready), 0);
        idle(1);
        check("clear.rerun_ready", 32'(d0_ready), 1);

        // clear on the completion edge of a failing beat
        beat(8'd5, 8'd5, 9'd1);
        idle(1);
        clear = 1'b1; idle(1); clear = 1'b0;
        check("clearwin.err_cnt", 32'(d0_err), 0);
        check("clearwin.err_pulse", 32'(d0_pulse), 0);

        // Saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) beat(8'(k), 8'(k + 1), 9'(2 * k + 1));
        idle(2);
        check("sat.d1_pass_cnt", 32'(d1_pass), 3);
        check("sat.d0_pass_cnt", 32'(d0_pass), 5);

        // rst with two beats in flight
        beat(8'd1, 8'd2, 9'd3);
        beat(8'd4, 8'd5, 9'd9);
        rst = 1'b1; idle(1); rst = 1'b0;
        check("rstmid.pass_cnt", 32'(d0_pass), 0);
        idle(3);
        check("rstmid.drained_pass_cnt", 32'(d0_pass), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(199) == 0);
            clear    = ($urandom_range(99) < 3);
            enable   = ($urandom_range(99) < 90);
            in_valid = 1'($urandom_range(1));
            in_a     = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 240)) : 8'($urandom);
            in_b     = 8'($urandom);
            sum      = {1'b0, in_a} + {1'b0, in_b};
            r        = $urandom_range(9);
            if (r < 7)       in_c = sum;
            else if (r == 7) in_c = sum ^ 9'h100;
            else             in_c = 9'($urandom);
            step();
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
